// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and load-lane helper for the data-memory unit.
package dmem_pkg;

   localparam logic [1:0] OPM_LOAD  = 2'b00;
   localparam logic [1:0] OPM_STORE = 2'b01;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } dmem_state_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // Pick the addressed lane out of a RAM word and zero/sign-extend it (f3[2] = unsigned).
   function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {off, 3'b000};
      case (f3[1:0])
         2'b00:   r = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   r = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// DEPTH x 32 synchronous RAM with four byte enables and a registered read port.
module dmem_sram_bank #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          re,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_unit.sv
// RISC-V load/store unit with start/done handshake, range/op checks and byte-enabled RAM.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of force-aligning them.
module data_mem_unit
   import dmem_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] op1,
   input  logic [ADDR_W-1:0] imm_data,
   input  logic [31:0]       op2,
   input  logic [1:0]        op_mode1,
   input  logic [2:0]        op_mode2,
   output logic              busy,
   output logic              done,
   output logic [31:0]       res,
   output logic              err,
   output logic [2:0]        state_dbg
);

   localparam int AW = $clog2(DEPTH);

   // Handshake: start is sampled only while idle; a request is accepted on the edge
   // where state is IDLE and start is high. busy covers accept+1 through the done
   // cycle; done is a single-cycle pulse and err/res are valid while done is high.

   dmem_state_t state, state_nxt;

   logic [ADDR_W-1:0] op1_q, imm_q;
   logic [31:0]       op2_q;
   logic [1:0]        mode_q;
   logic [2:0]        f3_q;
   logic              err_q;
   logic [31:0]       res_q;

   logic [ADDR_W-1:0] ea, word_idx;
   logic [1:0]        lane;
   logic              in_range, legal, fault;
   logic [3:0]        be;
   logic [31:0]       wdata, rdata, ld_val;

   assign ea       = op1_q + imm_q;
   assign word_idx = ea >> 2;
   assign in_range = word_idx < ADDR_W'(DEPTH);
   assign legal    = ((mode_q == OPM_LOAD) || (mode_q == OPM_STORE)) && f3_legal(f3_q);

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((f3_q[1:0] == 2'b01) && ea[0]) ||
                       ((f3_q[1:0] == 2'b10) && (ea[1:0] != 2'b00));
   assign fault      = !legal || !in_range || misaligned;
   assign lane       = ea[1:0];
`else
   assign fault = !legal || !in_range;
   // Misaligned halfwords/words are silently pulled down to their natural boundary.
   always_comb begin
      lane = ea[1:0];
      case (f3_q[1:0])
         2'b01:   lane[0] = 1'b0;
         2'b10:   lane    = 2'b00;
         default: lane    = ea[1:0];
      endcase
   end
`endif

   always_comb begin
      be    = 4'b0000;
      wdata = op2_q;
      case (f3_q[1:0])
         2'b00: begin
            be    = 4'b0001 << lane;
            wdata = {4{op2_q[7:0]}};
         end
         2'b01: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{op2_q[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   dmem_sram_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk   (clk),
      .re    (state == S_READ),
      .we    (state == S_WRITE),
      .addr  (ea[AW+1:2]),
      .be    (be),
      .wdata (wdata),
      .rdata (rdata)
   );

   assign ld_val = lane_extend(rdata, lane, f3_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // A store completes in its WRITE cycle, so WRITE doubles as the done cycle;
   // faulted operations go straight to RESP.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CALC;
         S_CALC: begin
            if (fault)                   state_nxt = S_RESP;
            else if (mode_q == OPM_STORE) state_nxt = S_WRITE;
            else                          state_nxt = S_READ;
         end
         S_READ:  state_nxt = S_RESP;
         S_WRITE: state_nxt = S_IDLE;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op1_q  <= '0;
         imm_q  <= '0;
         op2_q  <= '0;
         mode_q <= '0;
         f3_q   <= '0;
         err_q  <= 1'b0;
         res_q  <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            op1_q  <= op1;
            imm_q  <= imm_data;
            op2_q  <= op2;
            mode_q <= op_mode1;
            f3_q   <= op_mode2;
         end
         if (state == S_CALC) err_q <= fault;
         if (state == S_RESP && !err_q && mode_q == OPM_LOAD) res_q <= ld_val;
      end
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_RESP) || (state == S_WRITE);
   assign err       = (state == S_RESP) && err_q;
   // RAM data lands in RESP, so the fresh load value is forwarded in the done cycle.
   assign res       = (state == S_RESP && !err_q && mode_q == OPM_LOAD) ? ld_val : res_q;
   assign state_dbg = state;

endmodule
